// File: rtl/ws2812_framebuf_pkg.sv
// Shared constants and types for the ws2812 frame buffer.
// Colour word layout and the commit/pending state encoding.
package ws2812_framebuf_pkg;

  localparam int PIX_W = 24;
  localparam int R_HI  = 23;
  localparam int R_LO  = 16;
  localparam int G_HI  = 15;
  localparam int G_LO  = 8;
  localparam int B_HI  = 7;
  localparam int B_LO  = 0;

  localparam logic [7:0] BRIGHT_UNITY = 8'd255;

  typedef enum logic {
    IDLE,
    PENDING
  } fb_state_e;

endpackage

// File: rtl/ws2812_framebuf_scale8.sv
// One-stage registered brightness scaler: q = (c * (b + 1)) >> 8.
// b = 255 passes c through unchanged.
module ws2812_framebuf_scale8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] c,
  input  logic [7:0] b,
  output logic [7:0] q
);

  logic [15:0] p;

  assign p = {8'd0, c} * ({8'd0, b} + 16'd1);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (en)
      q <= 8'(p >> 8);
  end

endmodule

// File: rtl/ws2812_framebuf.sv
// Double-buffered pixel store feeding the ws2812c driver.
// Commits swap banks only at a pixel-0 fetch, so frames never tear.
module ws2812_framebuf
  import ws2812_framebuf_pkg::*;
#(
  parameter  int NUM_LEDS = 8,
  localparam int ADDR_W   = $clog2(NUM_LEDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_rgb,
  input  logic              commit,
  input  logic              bright_we,
  input  logic [7:0]        bright_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              new_address,
  output logic [7:0]        red_out,
  output logic [7:0]        green_out,
  output logic [7:0]        blue_out,
  output logic              pending,
  output logic              frame_start
);

  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(NUM_LEDS);

  fb_state_e        state;
  logic             nad_q;
  logic             front;
  logic             v1;
  logic             v2;
  logic [7:0]       bright;
  logic             fetch;
  logic             addr_ok;
  logic             wr_ok;
  logic             swap;
  logic             rd_bank;
  logic [PIX_W-1:0] rd;
  logic [PIX_W-1:0] mem0 [NUM_LEDS];
  logic [PIX_W-1:0] mem1 [NUM_LEDS];
  logic [7:0]       sr;
  logic [7:0]       sg;
  logic [7:0]       sb;

  assign fetch   = new_address & ~nad_q & ~reset;
  assign addr_ok = {1'b0, address} < LIM;
  assign wr_ok   = wr_en && ({1'b0, wr_addr} < LIM);
  assign swap    = fetch && (address == '0)
                   && (state == PENDING);
  // the fetch at a swap edge already reads the new front bank
  assign rd_bank = front ^ swap;
  assign pending = (state == PENDING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      nad_q       <= 1'b0;
      front       <= 1'b0;
      frame_start <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      bright      <= BRIGHT_UNITY;
    end else begin
      nad_q       <= new_address;
      front       <= rd_bank;
      frame_start <= fetch && (address == '0);
      v1          <= fetch;
      v2          <= v1;
      if (bright_we)
        bright <= bright_in;
      unique case (state)
        IDLE:    if (commit) state <= PENDING;
        PENDING: if (swap && !commit) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (front)
        mem0[wr_addr] <= wr_rgb;
      else
        mem1[wr_addr] <= wr_rgb;
    end
    if (fetch)
      rd <= !addr_ok ? '0 :
            rd_bank  ? mem1[address] : mem0[address];
  end

  ws2812_framebuf_scale8 u_r (
    .clk(clk), .reset(reset), .en(v1),
    .c(rd[R_HI:R_LO]), .b(bright), .q(sr)
  );

  ws2812_framebuf_scale8 u_g (
    .clk(clk), .reset(reset), .en(v1),
    .c(rd[G_HI:G_LO]), .b(bright), .q(sg)
  );

  ws2812_framebuf_scale8 u_b (
    .clk(clk), .reset(reset), .en(v1),
    .c(rd[B_HI:B_LO]), .b(bright), .q(sb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (v2) begin
      red_out   <= sr;
      green_out <= sg;
      blue_out  <= sb;
    end
  end

endmodule
